alu_writeback_stage: RTL
========================

// Module: alu_writeback_stage
// PURPOSE
//  Execute/writeback stage directly downstream of the 16x24 register file.
//  - Consumes the two read operands plus the decoded opcode and destination index.
//  - Computes a 24-bit result: single-cycle ALU ops, plus an iterative shift-add multiply.
//  - Drives the write port (WriteData/RD/RegWrite) back into the register file, one pulse per instruction.
// PARAMETERS
//  DATA_W      24  operand/result width
//  REG_ADDR_W  4   destination register index width (16 registers)
//  SHAMT_W     5   shift-amount width
// PORTS
//  Clock      in   1           single clock; all state updates on posedge
//  Reset      in   1           synchronous, active-high
//  InValid    in   1           upstream presents an instruction this cycle
//  InReady    out  1           stage accepts; transfer = InValid & InReady
//  Opcode     in   4           operation select (encoding in cpu24_pkg)
//  ReadRS     in   DATA_W      operand A from register file
//  ReadRT     in   DATA_W      operand B from register file
//  Shamt      in   SHAMT_W     shift amount for SLL/SRL
//  RDIn       in   REG_ADDR_W  destination index
//  WriteData  out  DATA_W      result to register file
//  RD         out  REG_ADDR_W  destination index to register file
//  RegWrite   out  1           one-cycle write strobe
//  Zero       out  1           last written result == 0
//  Overflow   out  1           signed overflow of last ADD/SUB, else 0
//  IllegalOp  out  1           one-cycle pulse for an undefined opcode
// BEHAVIOUR
//  - Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL, 8 MUL; 9-15 illegal.
//  - FSM states IDLE, MUL, WB:
//    - IDLE/WB: InReady=1.
//    - Accepting a non-MUL op goes to WB next cycle.
//    - Accepting MUL goes to MUL.
//    - WB with no transfer goes to IDLE.
//    - MUL: InReady=0; 5-bit counter runs 0..23, one partial product per cycle; after count 23, goes to WB.
//  - Latency (transfer cycle N):
//    - Single-cycle ops: RegWrite=1 in cycle N+1, giving 1 instr/cycle throughput back-to-back.
//    - MUL: RegWrite in cycle N+25.
//  - In WB: RegWrite=1 for exactly one cycle. WriteData/RD/Zero/Overflow are registered there and hold until the next WB.
//  - Arithmetic:
//    - ADD/SUB wrap mod 2^24; Overflow = signed overflow.
//    - SLT: signed compare, result 24'd1/24'd0.
//    - SLL/SRL are logical; Shamt>=24 yields 0.
//    - MUL: low 24 bits of ReadRS*ReadRT.
//  - Operands, opcode and RDIn are captured at transfer; upstream may change them afterwards.
//  - Illegal opcode: WB slot has RegWrite=0 and IllegalOp=1 for one cycle; WriteData/RD/Zero/Overflow unchanged.
//  - All RD values 0..15 are written; no hard-wired zero register.
//  - Reset (any state, incl. mid-MUL): state=IDLE, counter=0, in-flight op abandoned with no write.
//    - All outputs 0; InReady=0 while Reset is high, 1 the cycle after.
//  - InValid while InReady=0 is ignored; no queueing.
// CONFIGURATION
//  - CPU24_MUL_EN defined: MUL state and multiplier present, as above.
//  - CPU24_MUL_EN undefined: opcode 8 is treated as illegal (1-cycle, IllegalOp pulse, no write).
//    MUL state and counter are not synthesised.
// STRUCTURE
//  - cpu24_pkg: DATA_W/REG_ADDR_W constants, opcode localparams, FSM state encoding.
//  - Sub-module seq_multiplier: start/done handshake, 24-cycle shift-add, product low-24 out.
//    Instantiated only under CPU24_MUL_EN.
// TESTING
//  - Reset: hold Reset 2 cycles -> all outputs 0, InReady=0; release -> InReady=1, no RegWrite.
//  - Back-to-back: ADD R3=5+7, then SUB R4=5-7 in consecutive cycles
//    -> RegWrite on 2 consecutive cycles: (RD=3, 0x00000C), then (RD=4, 0xFFFFFE).
//  - Overflow/SLT: ADD 0x7FFFFF+1 -> WriteData 0x800000, Overflow=1;
//    SLT 0xFFFFFF vs 0x000001 -> 1; SLL by 24 -> 0, Zero=1.
//  - MUL: 0x000123*0x000456 -> InReady low 24 cycles, RegWrite at N+25 with 0x04EDC2;
//    InValid held during MUL is not accepted.
//  - Reset mid-MUL at cycle N+10 -> no RegWrite ever for that op; InReady=1 after release.
//  - Illegal opcode 12 (and 8 without CPU24_MUL_EN) -> IllegalOp pulse at N+1, RegWrite=0,
//    WriteData unchanged.

Source files
------------

// File: rtl/cpu24_pkg.sv
// Shared constants for the 24-bit execute/writeback stage: widths, opcode map, FSM states.
// CPU24_MUL_EN adds opcode 8 (MUL) to the legal set.
package cpu24_pkg;

    localparam int DATA_W     = 24;
    localparam int REG_ADDR_W = 4;
    localparam int SHAMT_W    = 5;
    localparam int OPC_W      = 4;

    localparam logic [OPC_W-1:0] OP_ADD = 4'd0;
    localparam logic [OPC_W-1:0] OP_SUB = 4'd1;
    localparam logic [OPC_W-1:0] OP_AND = 4'd2;
    localparam logic [OPC_W-1:0] OP_OR  = 4'd3;
    localparam logic [OPC_W-1:0] OP_XOR = 4'd4;
    localparam logic [OPC_W-1:0] OP_SLT = 4'd5;
    localparam logic [OPC_W-1:0] OP_SLL = 4'd6;
    localparam logic [OPC_W-1:0] OP_SRL = 4'd7;
    localparam logic [OPC_W-1:0] OP_MUL = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [OPC_W-1:0] op);
`ifdef CPU24_MUL_EN
        return (op <= OP_MUL);
`else
        return (op <= OP_SRL);
`endif
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: one partial product per cycle for W cycles after i_Start.
// o_Product is valid in the cycle o_Done is high (it includes that cycle's partial product).
module seq_multiplier #(
    parameter int W = 24
) (
    input  logic         i_Clock,
    input  logic         i_Reset,
    input  logic         i_Start,
    input  logic [W-1:0] i_A,
    input  logic [W-1:0] i_B,
    output logic         o_Done,
    output logic [W-1:0] o_Product
);

    localparam int CNT_W = $clog2(W);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_acc;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     w_acc_nxt;
    logic             w_last;

    // Only the low W bits of the product are kept, so bits shifted out of r_a are dropped.
    assign w_acc_nxt = r_acc + (r_b[0] ? r_a : '0);
    assign w_last    = r_busy && (r_cnt == CNT_W'(W - 1));
    assign o_Done    = w_last;
    assign o_Product = w_acc_nxt;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_a    <= '0;
            r_b    <= '0;
        end else if (i_Start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_a    <= i_A;
            r_b    <= i_B;
        end else if (r_busy) begin
            r_acc <= w_acc_nxt;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            if (w_last) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// Execute/writeback stage: single-cycle ALU plus optional iterative MUL, drives the regfile write port.
// Define CPU24_MUL_EN to build the MUL state and seq_multiplier; otherwise opcode 8 is illegal.
module alu_writeback_stage
    import cpu24_pkg::*;
#(
    parameter int DATA_W     = cpu24_pkg::DATA_W,
    parameter int REG_ADDR_W = cpu24_pkg::REG_ADDR_W,
    parameter int SHAMT_W    = cpu24_pkg::SHAMT_W
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_InValid,
    output logic                  o_InReady,
    input  logic [3:0]            i_Opcode,
    input  logic [DATA_W-1:0]     i_ReadRS,
    input  logic [DATA_W-1:0]     i_ReadRT,
    input  logic [SHAMT_W-1:0]    i_Shamt,
    input  logic [REG_ADDR_W-1:0] i_RDIn,
    output logic [DATA_W-1:0]     o_WriteData,
    output logic [REG_ADDR_W-1:0] o_RD,
    output logic                  o_RegWrite,
    output logic                  o_Zero,
    output logic                  o_Overflow,
    output logic                  o_IllegalOp
);

    localparam int MSB = DATA_W - 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_W-1:0]     r_write_data;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_reg_write;
    logic                  r_zero;
    logic                  r_overflow;
    logic                  r_illegal;

    logic                  w_ready;
    logic                  w_xfer;
    logic                  w_legal;
    logic                  w_is_mul;
    logic                  w_mul_done;
    logic [DATA_W-1:0]     w_alu;
    logic                  w_ovf;
    logic [DATA_W-1:0]     w_sum;
    logic [DATA_W-1:0]     w_diff;
    logic                  w_shift_big;

    assign w_ready  = (r_state != ST_MUL) && !i_Reset;
    assign w_xfer   = i_InValid && w_ready;
    assign w_legal  = op_is_legal(i_Opcode);

    assign w_sum       = i_ReadRS + i_ReadRT;
    assign w_diff      = i_ReadRS - i_ReadRT;
    assign w_shift_big = (i_Shamt >= SHAMT_W'(DATA_W));

    // Shifts operate on ReadRT (rd = rt << shamt), matching the classic R-type form.
    always_comb begin
        w_alu = '0;
        w_ovf = 1'b0;
        case (i_Opcode)
            OP_ADD: begin
                w_alu = w_sum;
                w_ovf = (i_ReadRS[MSB] == i_ReadRT[MSB]) && (w_sum[MSB] != i_ReadRS[MSB]);
            end
            OP_SUB: begin
                w_alu = w_diff;
                w_ovf = (i_ReadRS[MSB] != i_ReadRT[MSB]) && (w_diff[MSB] != i_ReadRS[MSB]);
            end
            OP_AND:  w_alu = i_ReadRS & i_ReadRT;
            OP_OR:   w_alu = i_ReadRS | i_ReadRT;
            OP_XOR:  w_alu = i_ReadRS ^ i_ReadRT;
            OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(i_ReadRS) < $signed(i_ReadRT))};
            OP_SLL:  w_alu = w_shift_big ? '0 : (i_ReadRT << i_Shamt);
            OP_SRL:  w_alu = w_shift_big ? '0 : (i_ReadRT >> i_Shamt);
            default: w_alu = '0;
        endcase
    end

`ifdef CPU24_MUL_EN
    logic [DATA_W-1:0]     w_product;
    logic [REG_ADDR_W-1:0] r_mul_rd;

    assign w_is_mul = (i_Opcode == OP_MUL);

    seq_multiplier #(.W(DATA_W)) u_mul (
        .i_Clock   (i_Clock),
        .i_Reset   (i_Reset),
        .i_Start   (w_xfer && w_is_mul),
        .i_A       (i_ReadRS),
        .i_B       (i_ReadRT),
        .o_Done    (w_mul_done),
        .o_Product (w_product)
    );
`else
    assign w_is_mul   = 1'b0;
    assign w_mul_done = 1'b0;
`endif

    always_ff @(posedge i_Clock) begin
        if (i_Reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_WB: begin
                if (w_xfer) w_state_nxt = (w_legal && w_is_mul) ? ST_MUL : ST_WB;
                else        w_state_nxt = ST_IDLE;
            end
            ST_MUL:  if (w_mul_done) w_state_nxt = ST_WB;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Result registers only move on a real write; illegal ops leave them untouched.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_write_data <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_zero       <= 1'b0;
            r_overflow   <= 1'b0;
            r_illegal    <= 1'b0;
`ifdef CPU24_MUL_EN
            r_mul_rd     <= '0;
`endif
        end else begin
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
            if (w_xfer) begin
                if (!w_legal) begin
                    r_illegal <= 1'b1;
                end else if (!w_is_mul) begin
                    r_reg_write  <= 1'b1;
                    r_write_data <= w_alu;
                    r_rd         <= i_RDIn;
                    r_zero       <= (w_alu == '0);
                    r_overflow   <= w_ovf;
                end
`ifdef CPU24_MUL_EN
                else begin
                    r_mul_rd <= i_RDIn;
                end
            end else if (r_state == ST_MUL && w_mul_done) begin
                r_reg_write  <= 1'b1;
                r_write_data <= w_product;
                r_rd         <= r_mul_rd;
                r_zero       <= (w_product == '0);
                r_overflow   <= 1'b0;
`endif
            end
        end
    end

    assign o_InReady   = w_ready;
    assign o_WriteData = r_write_data;
    assign o_RD        = r_rd;
    assign o_RegWrite  = r_reg_write;
    assign o_Zero      = r_zero;
    assign o_Overflow  = r_overflow;
    assign o_IllegalOp = r_illegal;

endmodule
